// File: rtl/exec_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the execute hazard controller:
// forward-select codes, FSM states and the stall/flush bundle.
package exec_hazard_ctrl_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    HOLD   = 2'd2
  } hzState_t;

  typedef struct packed {
    logic stallF;
    logic stallD;
    logic stallE;
    logic stallM;
    logic flushD;
    logic flushE;
  } hzCtl_t;

endpackage

// File: rtl/fwd_select.sv
// Forwarding comparator for one execute-stage source operand.
// The memory stage wins over writeback; x0 never forwards.
module fwd_select
  import exec_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rdM,
  input  logic             regWriteM,
  input  logic [REG_W-1:0] rdW,
  input  logic             regWriteW,
  output logic [1:0]       fwd
);

  logic hitM;
  logic hitW;

  assign hitM = regWriteM && (rdM != '0) && (rdM == rs);
  assign hitW = regWriteW && (rdW != '0) && (rdW == rs);

  always_comb begin
    fwd = FWD_RF;
    if (hitM)
      fwd = FWD_MEM;
    else if (hitW)
      fwd = FWD_WB;
  end

endmodule

// File: rtl/exec_hazard_ctrl.sv
// Execute-stage hazard controller: forwarding selects, load-use
// bubbles, branch flush, dmem freeze and stall/flush counters.
module exec_hazard_ctrl
  import exec_hazard_ctrl_pkg::*;
#(
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] Rs1_D,
  input  logic [REG_W-1:0] Rs2_D,
  input  logic [REG_W-1:0] Rs1_E,
  input  logic [REG_W-1:0] Rs2_E,
  input  logic [REG_W-1:0] RD_E,
  input  logic             LoadE,
  input  logic [REG_W-1:0] RD_M,
  input  logic             RegWriteM,
  input  logic [REG_W-1:0] RD_W,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             dmem_busy,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       busy_state
);

  localparam logic [2:0] BUB_LOAD =
    3'((LU_BUBBLES >= 2) ? (LU_BUBBLES - 2) : 0);

  hzState_t   state;
  hzState_t   stateNxt;
  hzState_t   effState;
  logic [2:0] bubCnt;
  logic [2:0] bubCntNxt;
  logic       resume;
  logic       resumeNxt;
  logic       flushEvt;
  logic       lu;
  hzCtl_t     ctl;

  fwd_select u_fwdA (
    .rs        (Rs1_E),
    .rdM       (RD_M),
    .regWriteM (RegWriteM),
    .rdW       (RD_W),
    .regWriteW (RegWriteW),
    .fwd       (ForwardA_E)
  );

  fwd_select u_fwdB (
    .rs        (Rs2_E),
    .rdM       (RD_M),
    .regWriteM (RegWriteM),
    .rdW       (RD_W),
    .regWriteW (RegWriteW),
    .fwd       (ForwardB_E)
  );

  assign lu = LoadE && (RD_E != '0) &&
              ((RD_E == Rs1_D) || (RD_E == Rs2_D));

  always_comb begin
    stateNxt  = state;
    bubCntNxt = bubCnt;
    resumeNxt = resume;
    flushEvt  = 1'b0;
    ctl       = '0;
    effState  = state;
    // release from HOLD acts as the resumed state in the same cycle
    if (state == HOLD && !dmem_busy)
      effState = resume ? BUBBLE : RUN;
    case (effState)
      RUN: begin
        stateNxt = RUN;
        if (dmem_busy) begin
          ctl.stallF = 1'b1;
          ctl.stallD = 1'b1;
          ctl.stallE = 1'b1;
          ctl.stallM = 1'b1;
          resumeNxt  = 1'b0;
          stateNxt   = HOLD;
        end else if (PCSrcE) begin
          ctl.flushD = 1'b1;
          ctl.flushE = 1'b1;
          flushEvt   = 1'b1;
        end else if (lu) begin
          ctl.stallF = 1'b1;
          ctl.stallD = 1'b1;
          ctl.flushE = 1'b1;
          if (LU_BUBBLES > 1) begin
            bubCntNxt = BUB_LOAD;
            stateNxt  = BUBBLE;
          end
        end
      end
      BUBBLE: begin
        if (dmem_busy) begin
          ctl.stallF = 1'b1;
          ctl.stallD = 1'b1;
          ctl.stallE = 1'b1;
          ctl.stallM = 1'b1;
          resumeNxt  = 1'b1;
          stateNxt   = HOLD;
        end else begin
          ctl.stallF = 1'b1;
          ctl.stallD = 1'b1;
          ctl.flushE = 1'b1;
          resumeNxt  = 1'b0;
          if (bubCnt == 3'd0) begin
            stateNxt = RUN;
          end else begin
            bubCntNxt = bubCnt - 3'd1;
            stateNxt  = BUBBLE;
          end
        end
      end
      HOLD: begin
        ctl.stallF = 1'b1;
        ctl.stallD = 1'b1;
        ctl.stallE = 1'b1;
        ctl.stallM = 1'b1;
        stateNxt   = HOLD;
      end
      default: stateNxt = RUN;
    endcase
    if (!rst) begin
      ctl      = '0;
      flushEvt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      bubCnt    <= '0;
      resume    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state  <= stateNxt;
      bubCnt <= bubCntNxt;
      resume <= resumeNxt;
      if (ctl.stallF)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flushEvt)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign StallF     = ctl.stallF;
  assign StallD     = ctl.stallD;
  assign StallE     = ctl.stallE;
  assign StallM     = ctl.stallM;
  assign FlushD     = ctl.flushD;
  assign FlushE     = ctl.flushE;
  assign busy_state = state;

endmodule

// File: tb/tb_exec_hazard_ctrl.sv
// Scoreboard bench: two controllers (1 and 3 load-use bubbles)
// driven in parallel and checked against a behavioural model.
module tb_exec_hazard_ctrl;

  typedef struct {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [5:0]  ctl;
    logic [31:0] sc;
    logic [31:0] fc;
    logic [1:0]  st;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
  logic       LoadE, RegWriteM, RegWriteW, PCSrcE, dmem_busy;

  logic [1:0]  fa1, fb1, st1, fa3, fb3, st3;
  logic        sF1, sD1, sE1, sM1, fD1, fE1;
  logic        sF3, sD3, sE3, sM3, fD3, fE3;
  logic [31:0] sc1, fc1, sc3, fc3;

  exp_t q1[$];
  exp_t q3[$];

  int          tests = 0;
  int          fails = 0;
  int          pend[2];
  bit          frozen[2];
  logic [31:0] mSc[2];
  logic [31:0] mFc[2];
  int          nb[2];

  always #5 clk = ~clk;

  exec_hazard_ctrl #(.LU_BUBBLES(1), .CNT_W(32)) u1 (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .RD_E(RD_E), .LoadE(LoadE), .RD_M(RD_M), .RegWriteM(RegWriteM),
    .RD_W(RD_W), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
    .dmem_busy(dmem_busy),
    .ForwardA_E(fa1), .ForwardB_E(fb1),
    .StallF(sF1), .StallD(sD1), .StallE(sE1), .StallM(sM1),
    .FlushD(fD1), .FlushE(fE1),
    .stall_cnt(sc1), .flush_cnt(fc1), .busy_state(st1)
  );

  exec_hazard_ctrl #(.LU_BUBBLES(3), .CNT_W(32)) u3 (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .RD_E(RD_E), .LoadE(LoadE), .RD_M(RD_M), .RegWriteM(RegWriteM),
    .RD_W(RD_W), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
    .dmem_busy(dmem_busy),
    .ForwardA_E(fa3), .ForwardB_E(fb3),
    .StallF(sF3), .StallD(sD3), .StallE(sE3), .StallM(sM3),
    .FlushD(fD3), .FlushE(fE3),
    .stall_cnt(sc3), .flush_cnt(fc3), .busy_state(st3)
  );

  function automatic logic [1:0] fwdRef(input logic [4:0] rs);
    if (RegWriteM && RD_M != 0 && RD_M == rs) return 2'b10;
    if (RegWriteW && RD_W != 0 && RD_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  // ctl bit order: StallF StallD StallE StallM FlushD FlushE
  function automatic exp_t model(input int k);
    exp_t e;
    bit   hz;
    e.fa  = fwdRef(Rs1_E);
    e.fb  = fwdRef(Rs2_E);
    e.sc  = mSc[k];
    e.fc  = mFc[k];
    e.st  = frozen[k] ? 2'd2 : (pend[k] > 0 ? 2'd1 : 2'd0);
    e.ctl = 6'b000000;
    hz = LoadE && RD_E != 0 && (RD_E == Rs1_D || RD_E == Rs2_D);
    if (!rst) begin
      pend[k] = 0;
      frozen[k] = 0;
      mSc[k] = 0;
      mFc[k] = 0;
      return e;
    end
    if (dmem_busy) begin
      e.ctl = 6'b111100;
      frozen[k] = 1;
    end else begin
      frozen[k] = 0;
      if (pend[k] > 0) begin
        e.ctl = 6'b110001;
        pend[k]--;
      end else if (PCSrcE) begin
        e.ctl = 6'b000011;
        mFc[k] = mFc[k] + 1;
      end else if (hz) begin
        e.ctl = 6'b110001;
        pend[k] = nb[k] - 1;
      end
    end
    if (e.ctl[5]) mSc[k] = mSc[k] + 1;
    return e;
  endfunction

  task automatic drive(
    input logic r, input logic [4:0] rs1d, input logic [4:0] rs2d,
    input logic [4:0] rs1e, input logic [4:0] rs2e,
    input logic [4:0] rde, input logic lde,
    input logic [4:0] rdm, input logic rwm,
    input logic [4:0] rdw, input logic rww,
    input logic pcs, input logic busy);
    @(posedge clk);
    #1;
    rst = r; Rs1_D = rs1d; Rs2_D = rs2d; Rs1_E = rs1e; Rs2_E = rs2e;
    RD_E = rde; LoadE = lde; RD_M = rdm; RegWriteM = rwm;
    RD_W = rdw; RegWriteW = rww; PCSrcE = pcs; dmem_busy = busy;
    q1.push_back(model(0));
    q3.push_back(model(1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("u1.ForwardA_E", 32'(fa1), 32'(e.fa));
      chk("u1.ForwardB_E", 32'(fb1), 32'(e.fb));
      chk("u1.ctl", 32'({sF1, sD1, sE1, sM1, fD1, fE1}), 32'(e.ctl));
      chk("u1.stall_cnt", sc1, e.sc);
      chk("u1.flush_cnt", fc1, e.fc);
      chk("u1.busy_state", 32'(st1), 32'(e.st));
    end
    if (q3.size() > 0) begin
      e = q3.pop_front();
      chk("u3.ForwardA_E", 32'(fa3), 32'(e.fa));
      chk("u3.ForwardB_E", 32'(fb3), 32'(e.fb));
      chk("u3.ctl", 32'({sF3, sD3, sE3, sM3, fD3, fE3}), 32'(e.ctl));
      chk("u3.stall_cnt", sc3, e.sc);
      chk("u3.flush_cnt", fc3, e.fc);
      chk("u3.busy_state", 32'(st3), 32'(e.st));
    end
  end

  initial begin
    nb[0] = 1; nb[1] = 3;
    for (int k = 0; k < 2; k++) begin
      pend[k] = 0; frozen[k] = 0; mSc[k] = 0; mFc[k] = 0;
    end
    rst = 0; Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0; RD_E = 0;
    LoadE = 0; RD_M = 0; RegWriteM = 0; RD_W = 0; RegWriteW = 0;
    PCSrcE = 0; dmem_busy = 0;
    @(posedge clk);
    drive(0, 7, 7, 5, 5, 7, 1, 5, 1, 5, 1, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // RAW chain: mem stage wins, x0 never forwards
    drive(1, 0, 0, 5, 6, 0, 0, 5, 1, 5, 1, 0, 0);
    drive(1, 0, 0, 5, 5, 0, 0, 0, 1, 5, 0, 0, 0);
    drive(1, 0, 0, 9, 5, 0, 0, 3, 1, 5, 1, 0, 0);
    // load-use on rs2
    drive(1, 1, 7, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 7, 0, 0, 0, 0, 7, 1, 0, 0);
    idle(4);
    // branch beats load-use
    drive(1, 7, 0, 0, 0, 7, 1, 0, 0, 0, 0, 1, 0);
    idle(2);
    // dmem busy for 4 cycles in the middle of a bubble run
    drive(1, 3, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(4);
    // busy straight out of RUN
    for (int i = 0; i < 3; i++)
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    // reset mid-bubble
    drive(1, 4, 4, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    for (int i = 0; i < 3000; i++)
      drive(($urandom_range(0, 199) != 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0),
            5'($urandom_range(0, 3)), 1'($urandom),
            5'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 6) == 0));
    idle(2);
    @(negedge clk);
    #1;
    chk("queue_drain", 32'(q1.size() + q3.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
